// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the ping-pong frame buffer:
//   - wr_state_t      : capture-side writer FSM states
//   - C_DEF_*         : default image / bus dimensions
//   - C_BG_COLOR      : colour shown outside the image or before a first frame
//   - C_NUM_BANKS     : number of frame banks (ping + pong)
//   - sat_inc8()      : 8-bit saturating increment used by the drop counter
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,   // idle, waiting for a word at address 0
        WRITE    = 2'd1,   // storing a frame into the writer bank
        HOLD     = 2'd2    // complete frame parked until the display takes it
    } wr_state_t;

    localparam int unsigned C_DEF_IMG_COLS    = 80;
    localparam int unsigned C_DEF_IMG_ROWS    = 60;
    localparam int unsigned C_DEF_NB_IMG_PXLS = 13;
    localparam int unsigned C_DEF_NB_BUF      = 16;
    localparam int unsigned C_DEF_NB_XY       = 7;

    localparam logic [15:0] C_BG_COLOR = 16'h07E0;

    localparam int unsigned C_NUM_BANKS = 2;

    // Counts up to 255 and then sticks there.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage : fb_pkg

// File: rtl/fb_bank.sv
// -----------------------------------------------------------------------------
// fb_bank
// One frame bank: simple dual-port RAM, one write port and one read port with a
// registered read (one cycle latency). Maps onto inferred block RAM; contents
// are not reset.
// Ports:
//   clk    in  1        clock
//   we     in  1        write enable
//   waddr  in  AW       write address
//   wdata  in  DW       write data
//   re     in  1        read enable (rdata holds while low)
//   raddr  in  AW       read address
//   rdata  out DW       registered read data
// -----------------------------------------------------------------------------
module fb_bank #(
    parameter int unsigned DEPTH = 4800,
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range read addresses are possible (display outside the image);
    // the caller replaces that data with the background colour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule : fb_bank

// File: rtl/fb_pingpong.sv
// -----------------------------------------------------------------------------
// fb_pingpong
// Double-buffered frame store between a camera capture stream and a display
// scanner. Capture writes into the writer bank (always ~rd_bank) while the
// display reads the other bank. A completed frame is handed over at the next
// display frame start (rd_req at x=0, y=0); frames completing while a handover
// is pending are dropped and counted.
// Ports:
//   clk        in  1               system clock
//   rst_n      in  1               asynchronous active-low reset
//   cap_we     in  1               capture write strobe
//   cap_addr   in  C_NB_IMG_PXLS   capture pixel address (row-major)
//   cap_data   in  C_NB_BUF        capture pixel (RGB565)
//   freeze     in  1               suppress capture, abandon partial frame
//   rd_req     in  1               display pixel request
//   rd_x       in  C_NB_XY         display column
//   rd_y       in  C_NB_XY         display row
//   rd_color   out C_NB_BUF        pixel colour, two cycles after rd_req
//   rd_valid   out 1               one-cycle pulse qualifying rd_color
//   wr_bank    out 1               bank currently owned by capture
//   rd_bank    out 1               bank currently shown by the display
//   frame_cnt  out 8               completed frames (wraps)
//   drop_cnt   out 8               frames lost while a frame was pending (sat.)
// -----------------------------------------------------------------------------
module fb_pingpong
    import fb_pkg::*;
#(
    parameter int unsigned           C_IMG_COLS    = C_DEF_IMG_COLS,
    parameter int unsigned           C_IMG_ROWS    = C_DEF_IMG_ROWS,
    parameter int unsigned           C_NB_IMG_PXLS = C_DEF_NB_IMG_PXLS,
    parameter int unsigned           C_NB_BUF      = C_DEF_NB_BUF,
    parameter int unsigned           C_NB_XY       = C_DEF_NB_XY,
    parameter logic [C_NB_BUF-1:0]   C_BG_COLOR    = fb_pkg::C_BG_COLOR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_we,
    input  logic [C_NB_IMG_PXLS-1:0] cap_addr,
    input  logic [C_NB_BUF-1:0]      cap_data,
    input  logic                     freeze,
    input  logic                     rd_req,
    input  logic [C_NB_XY-1:0]       rd_x,
    input  logic [C_NB_XY-1:0]       rd_y,
    output logic [C_NB_BUF-1:0]      rd_color,
    output logic                     rd_valid,
    output logic                     wr_bank,
    output logic                     rd_bank,
    output logic [7:0]               frame_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned              C_DEPTH = C_IMG_COLS * C_IMG_ROWS;
    localparam logic [C_NB_IMG_PXLS-1:0] C_LAST  = C_NB_IMG_PXLS'(C_DEPTH - 1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    wr_state_t   state_reg;
    logic        ready_reg;        // a complete frame waits in the writer bank
    logic        have_frame_reg;   // display has taken at least one frame
    logic        rd_bank_reg;
    logic [7:0]  frame_cnt_reg;
    logic [7:0]  drop_cnt_reg;

    // ------------------------------------------------------------------
    // Read pipeline state
    // ------------------------------------------------------------------
    logic                 rd_valid1_reg;   // request accepted, RAM read in flight
    logic                 rd_sel_reg;      // bank sampled with the request
    logic                 rd_bg_reg;       // request resolves to background
    logic                 rd_valid_reg;
    logic [C_NB_BUF-1:0]  rd_color_reg;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                     frame_start;
    logic                     swap;
    logic                     rd_bank_eff;
    logic                     have_frame_eff;
    logic                     wr_bank_sel;
    logic                     addr_is_first;
    logic                     addr_is_last;
    logic                     addr_in_range;
    logic                     sof_ok;
    logic                     wr_fire;
    logic                     complete;
    logic                     drop;
    logic                     rd_oob;
    logic [C_NB_IMG_PXLS-1:0] rd_addr;

    assign frame_start = rd_req && (rd_x == '0) && (rd_y == '0);

    // Only the ready value from before this cycle can trigger a handover, so a
    // frame finishing on the very cycle of a frame start waits for the next one.
    assign swap = frame_start && ready_reg;

    // The pixel request that causes a swap already belongs to the new frame.
    assign rd_bank_eff    = rd_bank_reg ^ swap;
    assign have_frame_eff = have_frame_reg | swap;

    assign wr_bank_sel   = ~rd_bank_reg;
    assign addr_is_first = (cap_addr == '0);
    assign addr_is_last  = (cap_addr == C_LAST);
    assign addr_in_range = (32'(cap_addr) < C_DEPTH);

    // A new frame may only start while no completed frame is pending; after a
    // freeze out of HOLD the pending frame must not be overwritten before the
    // display has taken it.
    assign sof_ok = (state_reg == WAIT_SOF) && addr_is_first && !ready_reg;

    assign wr_fire  = cap_we && !freeze && addr_in_range
                      && (sof_ok || (state_reg == WRITE));
    assign complete = wr_fire && addr_is_last && (state_reg == WRITE);
    assign drop     = cap_we && addr_is_last
                      && ((state_reg == HOLD) || (state_reg == WAIT_SOF));

    // Row-major address, truncated to the pixel address width.
    assign rd_addr = C_NB_IMG_PXLS'(32'(rd_y) * C_IMG_COLS + 32'(rd_x));
    assign rd_oob  = (32'(rd_x) >= C_IMG_COLS) || (32'(rd_y) >= C_IMG_ROWS);

    // ------------------------------------------------------------------
    // Writer FSM, handover and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= WAIT_SOF;
            ready_reg      <= 1'b0;
            have_frame_reg <= 1'b0;
            rd_bank_reg    <= 1'b0;
            frame_cnt_reg  <= 8'd0;
            drop_cnt_reg   <= 8'd0;
        end else begin
            if (freeze) begin
                state_reg <= WAIT_SOF;
            end else begin
                case (state_reg)
                    WAIT_SOF: begin
                        if (wr_fire) begin
                            state_reg <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (complete) begin
                            state_reg <= HOLD;
                        end
                    end
                    HOLD: begin
                        // The display has taken the frame; the old display
                        // bank is free for capture again.
                        if (swap) begin
                            state_reg <= WAIT_SOF;
                        end
                    end
                    default: begin
                        state_reg <= WAIT_SOF;
                    end
                endcase
            end

            if (complete) begin
                ready_reg <= 1'b1;
            end else if (swap) begin
                ready_reg <= 1'b0;
            end

            rd_bank_reg    <= rd_bank_eff;
            have_frame_reg <= have_frame_eff;

            if (complete) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            if (drop) begin
                drop_cnt_reg <= sat_inc8(drop_cnt_reg);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame banks
    // ------------------------------------------------------------------
    logic [C_NUM_BANKS-1:0] bank_we;
    logic [C_NB_BUF-1:0]    bank_rdata [C_NUM_BANKS];

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_BANKS; gi++) begin : g_bank
            assign bank_we[gi] = wr_fire && (wr_bank_sel == 1'(gi));

            fb_bank #(
                .DEPTH (C_DEPTH),
                .AW    (C_NB_IMG_PXLS),
                .DW    (C_NB_BUF)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gi]),
                .waddr (cap_addr),
                .wdata (cap_data),
                .re    (rd_req),
                .raddr (rd_addr),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 runs alongside the RAM read, stage 2 selects
    // the bank sampled with the request (or background) and registers it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid1_reg <= 1'b0;
            rd_sel_reg    <= 1'b0;
            rd_bg_reg     <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_color_reg  <= '0;
        end else begin
            rd_valid1_reg <= rd_req;
            if (rd_req) begin
                rd_sel_reg <= rd_bank_eff;
                rd_bg_reg  <= rd_oob || !have_frame_eff;
            end

            rd_valid_reg <= rd_valid1_reg;
            if (rd_valid1_reg) begin
                rd_color_reg <= rd_bg_reg ? C_BG_COLOR : bank_rdata[rd_sel_reg];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_color  = rd_color_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_bank   = rd_bank_reg;
    assign wr_bank   = wr_bank_sel;
    assign frame_cnt = frame_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule : fb_pingpong

// File: tb/tb_fb_pingpong.sv
// -----------------------------------------------------------------------------
// tb_fb_pingpong
// Directed bench for fb_pingpong at default parameters (80x60, RGB565).
// Scenarios run in order and build on each other's state; expected values are
// hand-computed from the frame data pattern data = addr + offset.
// -----------------------------------------------------------------------------
module tb_fb_pingpong;

    localparam int          COLS  = 80;
    localparam int          ROWS  = 60;
    localparam int          DEPTH = COLS * ROWS;
    localparam logic [15:0] BG    = 16'h07E0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cap_we;
    logic [12:0] cap_addr;
    logic [15:0] cap_data;
    logic        freeze;
    logic        rd_req;
    logic [6:0]  rd_x;
    logic [6:0]  rd_y;
    logic [15:0] rd_color;
    logic        rd_valid;
    logic        wr_bank;
    logic        rd_bank;
    logic [7:0]  frame_cnt;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fb_pingpong dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_we    (cap_we),
        .cap_addr  (cap_addr),
        .cap_data  (cap_data),
        .freeze    (freeze),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_color  (rd_color),
        .rd_valid  (rd_valid),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes addresses lo..hi with data = addr + off, one word per cycle.
    task automatic write_range(input int lo, input int hi, input logic [15:0] off);
        for (int a = lo; a <= hi; a++) begin
            cap_we   = 1'b1;
            cap_addr = 13'(a);
            cap_data = 16'(a) + off;
            tick();
        end
        cap_we = 1'b0;
        $display("write addr %0d..%0d off=%h -> frame_cnt=%0d drop_cnt=%0d rd_bank=%0b",
                 lo, hi, off, frame_cnt, drop_cnt, rd_bank);
    endtask

    // One display request; returns rd_valid at N+1, N+2, N+3 and rd_color at N+2.
    task automatic read_px(input int x, input int y,
                           output logic v1, output logic v2, output logic v3,
                           output logic [15:0] col);
        rd_req = 1'b1;
        rd_x   = 7'(x);
        rd_y   = 7'(y);
        tick();
        rd_req = 1'b0;
        v1 = rd_valid;
        tick();
        v2  = rd_valid;
        col = rd_color;
        tick();
        v3 = rd_valid;
        $display("read (%0d,%0d) -> color=%h valid N+1/N+2/N+3=%0b%0b%0b rd_bank=%0b",
                 x, y, col, v1, v2, v3, rd_bank);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_data = '0;
        freeze = 1'b0; rd_req = 1'b0; rd_x = '0; rd_y = '0;
        tick(); tick();
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bank got %b want 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL reset_wr_bank got %b want 1", wr_bank); end
        n_checks++; if (rd_color !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_color got %h want 0000", rd_color); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_bg_before_frame();
        logic v1, v2, v3;
        logic [15:0] col;
        read_px(3, 3, v1, v2, v3, col);
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL bg_valid_n1 got %b want 0", v1); end
        n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL bg_valid_n2 got %b want 1", v2); end
        n_checks++; if (v3 !== 1'b0) begin n_fail++; $display("FAIL bg_valid_n3 got %b want 0", v3); end
        n_checks++; if (col !== BG) begin n_fail++; $display("FAIL bg_no_frame_color got %h want %h", col, BG); end
    endtask

    // Ramp frame, then two more frames with no display frame start.
    task automatic test_drop_and_ramp();
        logic v1, v2, v3;
        logic [15:0] col;
        write_range(0, DEPTH - 1, 16'h0000);
        write_range(0, DEPTH - 1, 16'h1000);
        write_range(0, DEPTH - 1, 16'h2000);
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_frame_cnt got %0d want 1", frame_cnt); end
        n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL drop_drop_cnt got %0d want 2", drop_cnt); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL drop_rd_bank_no_start got %b want 0", rd_bank); end
        read_px(0, 0, v1, v2, v3, col);
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL ramp_swap_rd_bank got %b want 1", rd_bank); end
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL ramp_swap_wr_bank got %b want 0", wr_bank); end
        n_checks++; if (col !== 16'h0000) begin n_fail++; $display("FAIL ramp_px00 got %h want 0000", col); end
        read_px(5, 2, v1, v2, v3, col);
        n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL ramp_px52_valid got %b want 1", v2); end
        n_checks++; if (col !== 16'd165) begin n_fail++; $display("FAIL ramp_px52 got %h want %h", col, 16'd165); end
        read_px(79, 59, v1, v2, v3, col);
        n_checks++; if (col !== 16'h12BF) begin n_fail++; $display("FAIL ramp_px_last got %h want 12bf", col); end
        read_px(100, 10, v1, v2, v3, col);
        n_checks++; if (v2 !== 1'b1) begin n_fail++; $display("FAIL oob_x_valid got %b want 1", v2); end
        n_checks++; if (col !== BG) begin n_fail++; $display("FAIL oob_x_color got %h want %h", col, BG); end
        read_px(10, 100, v1, v2, v3, col);
        n_checks++; if (col !== BG) begin n_fail++; $display("FAIL oob_y_color got %h want %h", col, BG); end
    endtask

    task automatic test_freeze();
        logic v1, v2, v3;
        logic [15:0] col;
        write_range(0, 1999, 16'h4000);
        cap_we = 1'b1; cap_addr = 13'd2000; cap_data = 16'h47D0; freeze = 1'b1;
        tick();
        cap_we = 1'b0; freeze = 1'b0;
        $display("freeze pulse at addr 2000");
        write_range(2001, DEPTH - 1, 16'h4000);
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL freeze_frame_cnt got %0d want 1", frame_cnt); end
        n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL freeze_drop_cnt got %0d want 3", drop_cnt); end
        read_px(0, 0, v1, v2, v3, col);
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL freeze_no_swap got %b want 1", rd_bank); end
        n_checks++; if (col !== 16'h0000) begin n_fail++; $display("FAIL freeze_repeat_px00 got %h want 0000", col); end
        write_range(0, DEPTH - 1, 16'h5000);
        n_checks++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL freeze_next_frame_cnt got %0d want 2", frame_cnt); end
        read_px(0, 0, v1, v2, v3, col);
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL freeze_swap got %b want 0", rd_bank); end
        n_checks++; if (col !== 16'h5000) begin n_fail++; $display("FAIL freeze_px00 got %h want 5000", col); end
        read_px(5, 2, v1, v2, v3, col);
        n_checks++; if (col !== 16'h50A5) begin n_fail++; $display("FAIL freeze_px52 got %h want 50a5", col); end
    endtask

    task automatic test_same_cycle();
        logic v1, v2, v3;
        logic [15:0] col;
        write_range(0, DEPTH - 2, 16'h6000);
        cap_we = 1'b1; cap_addr = 13'(DEPTH - 1); cap_data = 16'h72BF;
        rd_req = 1'b1; rd_x = '0; rd_y = '0;
        tick();
        cap_we = 1'b0; rd_req = 1'b0;
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL same_cycle_no_swap got %b want 0", rd_bank); end
        n_checks++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL same_cycle_frame_cnt got %0d want 3", frame_cnt); end
        tick();
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL same_cycle_valid got %b want 1", rd_valid); end
        n_checks++; if (rd_color !== 16'h5000) begin n_fail++; $display("FAIL same_cycle_old_px00 got %h want 5000", rd_color); end
        $display("completion + frame start same cycle -> rd_bank=%0b color=%h", rd_bank, rd_color);
        read_px(0, 0, v1, v2, v3, col);
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL same_cycle_later_swap got %b want 1", rd_bank); end
        n_checks++; if (col !== 16'h6000) begin n_fail++; $display("FAIL same_cycle_new_px00 got %h want 6000", col); end
        read_px(79, 59, v1, v2, v3, col);
        n_checks++; if (col !== 16'h72BF) begin n_fail++; $display("FAIL same_cycle_px_last got %h want 72bf", col); end
    endtask

    task automatic test_reset_mid_frame();
        logic v1, v2, v3;
        logic [15:0] col;
        write_range(0, 99, 16'h7000);
        #3;
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_bank got %b want 0", rd_bank); end
        n_checks++; if (wr_bank !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_bank got %b want 1", wr_bank); end
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_drop_cnt got %0d want 0", drop_cnt); end
        n_checks++; if (rd_color !== 16'h0000) begin n_fail++; $display("FAIL midrst_rd_color got %h want 0000", rd_color); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_valid got %b want 0", rd_valid); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        write_range(100, DEPTH - 1, 16'h7000);
        n_checks++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_no_resume got %0d want 0", frame_cnt); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_drop got %0d want 1", drop_cnt); end
        write_range(0, DEPTH - 1, 16'h8000);
        n_checks++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_frame_done got %0d want 1", frame_cnt); end
        read_px(0, 0, v1, v2, v3, col);
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL midrst_swap got %b want 1", rd_bank); end
        read_px(5, 2, v1, v2, v3, col);
        n_checks++; if (col !== 16'h80A5) begin n_fail++; $display("FAIL midrst_px52 got %h want 80a5", col); end
    endtask

    initial begin
        test_reset();
        test_bg_before_frame();
        test_drop_and_ramp();
        test_freeze();
        test_same_cycle();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fb_pingpong
